// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-requester write-arbitrated FIFO.
//   DEF_WIDTH / DEF_DEPTH : default data width and FIFO depth.
//   pri_e                 : round-robin preference between the two writers.
package fifo_arb_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 8;

  typedef enum logic {
    PRI0 = 1'b0,  // requester 0 wins a tie
    PRI1 = 1'b1   // requester 1 wins a tie
  } pri_e;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage array for fifo_wr_arbiter.
//   clk   : rising-edge clock
//   we    : write enable; wdata is stored at waddr on the edge
//   waddr : write address
//   wdata : write data
//   re    : read enable; rdata is loaded from raddr on the edge, else holds
//   raddr : read address
//   rdata : registered read data
module fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset; emptiness is
  // tracked by the pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// FIFO with two arbitrated write requesters and one reader.
// Ties between the writers alternate round-robin; a writer is never granted
// while the FIFO is full, even if a pop happens in the same cycle.
//   clk, rst        : clock, synchronous active-high reset
//   req0/data0/gnt0 : requester 0 write request, data, grant (write this edge)
//   req1/data1/gnt1 : requester 1 write request, data, grant (write this edge)
//   rd_en           : pop request, ignored while empty
//   rd_data         : popped word, valid one cycle after the pop
//   rd_valid        : one-cycle pulse marking rd_data after each pop
//   full, empty     : occupancy flags decoded from count
//   count           : current occupancy, 0..DEPTH
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0,
  input  logic [WIDTH-1:0]         data0,
  output logic                     gnt0,
  input  logic                     req1,
  input  logic [WIDTH-1:0]         data1,
  output logic                     gnt1,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pri_e             pri_q, pri_d;
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             rd_valid_q;
  logic             rd_seen_q;    // a pop has happened since reset
  logic             wr;
  logic             pop;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] mem_rdata;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

  // Arbitration: a lone request always wins; a tie goes to the preferred side.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && !full) begin
      if (req0 && req1) begin
        gnt0 = (pri_q == PRI0);
        gnt1 = (pri_q == PRI1);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  assign wr    = gnt0 | gnt1;
  assign wdata = gnt1 ? data1 : data0;
  // Empty gates the read, so a simultaneous write into an empty FIFO is not
  // popped in the same cycle.
  assign pop   = rd_en && !empty;

  always_comb begin
    pri_d   = pri_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (gnt0) pri_d = PRI1;
    if (gnt1) pri_d = PRI0;
    // DEPTH is a power of two, so the natural pointer overflow is the wrap.
    if (wr)  wptr_d = wptr_q + AW'(1);
    if (pop) rptr_d = rptr_q + AW'(1);
    case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      pri_q      <= PRI0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      pri_q      <= pri_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      rd_valid_q <= pop;
      if (pop) rd_seen_q <= 1'b1;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wptr_q),
    .wdata (wdata),
    .re    (pop),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  // The storage read register is not reset; until the first pop after reset
  // the output is forced to zero. After that it holds the last popped word.
  assign rd_data  = rd_seen_q ? mem_rdata : '0;
  assign rd_valid = rd_valid_q;

endmodule
